// File: rtl/din_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : din_cond_pkg
// Description : Shared types and default constants for the digital-input
//               conditioning path (debouncer and edge detector stages).
//               - deb_state_t : debounce FSM state encoding
//               - DEB_SYNC_STAGES / DEB_STABLE_CYCLES : default parameters
// Revision    : 1.0 - initial release
// ============================================================================
package din_cond_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } deb_state_t;

  localparam int DEB_SYNC_STAGES   = 2;
  localparam int DEB_STABLE_CYCLES = 4;

endpackage : din_cond_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : Multi-flop synchronizer for a single asynchronous bit.
//               Reset clears every stage to 0.
// Ports       : clk    - clock, rising edge
//               resetn - synchronous active-low reset
//               d      - asynchronous input
//               q      - synchronized output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be 2 or more");
  end

  logic [SYNC_STAGES-1:0] r_sync;

  // Stage 0 captures d; the value marches toward the MSB each edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/din_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : din_debouncer
// Description : Synchronizes a raw bouncing input and passes a level change
//               to dout only after STABLE_CYCLES consecutive stable samples.
//               Aborted candidate transitions produce a one-cycle glitch
//               pulse for diagnostics.
// Ports       : clk     - clock, rising edge
//               resetn  - synchronous active-low reset
//               din     - raw asynchronous input
//               dout    - debounced level (registered)
//               pending - candidate transition being qualified
//               glitch  - one-cycle pulse after an aborted candidate
// Revision    : 1.0 - initial release
// ============================================================================
module din_debouncer
  import din_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = DEB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout,
  output logic pending,
  output logic glitch
);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("din_debouncer: STABLE_CYCLES must be 2 or more");
  end

  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s;
  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dout;
  logic             w_dout_nxt;
  logic             r_glitch;
  logic             w_glitch_nxt;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (din),
    .q      (w_s)
  );

  // State register, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= LOW;
      r_cnt    <= '0;
      r_dout   <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dout   <= w_dout_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

  // Next-state and counter logic. The first differing sample counts as 1,
  // so the transition is accepted on the STABLE_CYCLES-th sample.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LOW: begin
        if (w_s) begin
          w_state_nxt = RISE_PEND;
          w_cnt_nxt   = C_CNT_ONE;
        end
      end
      RISE_PEND: begin
        if (!w_s) begin
          w_state_nxt = LOW;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = HIGH;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      HIGH: begin
        if (!w_s) begin
          w_state_nxt = FALL_PEND;
          w_cnt_nxt   = C_CNT_ONE;
        end
      end
      FALL_PEND: begin
        if (w_s) begin
          w_state_nxt = HIGH;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = LOW;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode. dout follows the committed level of the next state, so
  // a pending state keeps the old level until qualification completes.
  always_comb begin
    w_dout_nxt   = (w_state_nxt == HIGH) || (w_state_nxt == FALL_PEND);
    w_glitch_nxt = ((r_state == RISE_PEND) && !w_s) ||
                   ((r_state == FALL_PEND) &&  w_s);
    pending      = (r_state == RISE_PEND) || (r_state == FALL_PEND);
  end

  assign dout   = r_dout;
  assign glitch = r_glitch;

endmodule : din_debouncer
`default_nettype wire

// File: tb/tb_din_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_din_debouncer
// Description : Self-checking bench for din_debouncer (default parameters).
//               Fixed vector table, hand-written corner sequences and a
//               randomized run against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_din_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk;
  logic resetn;
  logic din;
  logic dout;
  logic pending;
  logic glitch;

  int n_tests;
  int n_fail;
  int cyc;

  din_debouncer u_dut (
    .clk     (clk),
    .resetn  (resetn),
    .din     (din),
    .dout    (dout),
    .pending (pending),
    .glitch  (glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: a delay line for the synchronizer, then a count of
  // consecutive samples that disagree with the committed level. Reaching
  // STABLE flips the level; an agreeing sample while counting is an abort.
  // --------------------------------------------------------------------------
  logic m_delay[$];
  logic m_dout;
  logic m_glitch;
  int   m_run;

  function automatic logic m_pending();
    return (m_run > 0);
  endfunction

  task automatic model_reset();
    m_delay.delete();
    for (int i = 0; i < SYNC; i++) m_delay.push_front(1'b0);
    m_dout   = 1'b0;
    m_glitch = 1'b0;
    m_run    = 0;
  endtask

  task automatic model_edge(input logic rst_n, input logic d);
    logic s;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = m_delay[$];
      void'(m_delay.pop_back());
      m_delay.push_front(d);
      m_glitch = 1'b0;
      if (s != m_dout) begin
        m_run++;
        if (m_run == STABLE) begin
          m_dout = ~m_dout;
          m_run  = 0;
        end
      end else if (m_run > 0) begin
        m_glitch = 1'b1;
        m_run    = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after rising.
  task automatic step(input logic rst_n, input logic d);
    @(negedge clk);
    resetn = rst_n;
    din    = d;
    @(posedge clk);
    model_edge(rst_n, d);
    #1;
    cyc++;
    check("model_dout",    dout,    m_dout);
    check("model_pending", pending, m_pending());
    check("model_glitch",  glitch,  m_glitch);
  endtask

  typedef struct {
    logic rst_n;
    logic d;
    logic e_dout;
    logic e_pend;
    logic e_glitch;
  } vec_t;

  vec_t vecs[19];
  int   gcount;
  logic pat[13];
  int   len;
  logic lvl;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    resetn  = 1'b0;
    din     = 1'b0;
    model_reset();

    // Reset hold with din=1, quiet baseline, 2-cycle pulse, clean rise.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rst_n, vecs[i].d);
      check("vec_dout",    dout,    vecs[i].e_dout);
      check("vec_pending", pending, vecs[i].e_pend);
      check("vec_glitch",  glitch,  vecs[i].e_glitch);
    end

    // Fall glitch: 3 low cycles from HIGH give one abort, dout stays 1.
    gcount = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, (i < 3) ? 1'b0 : 1'b1);
      if (glitch) gcount++;
      check("fallg_dout", dout, 1'b1);
    end
    check("fallg_count", (gcount == 1), 1'b1);

    // Clean fall: dout drops 5 edges after the first low sample.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 4) check("fall_dout_before", dout, 1'b1);
      if (i == 5) check("fall_dout_after",  dout, 1'b0);
    end

    // Bounce 1,0,1,0 then 1 held: two aborts, rise 5 edges after last 0->1.
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    gcount = 0;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, pat[i]);
      if (glitch) gcount++;
      if (i == 8) check("bounce_dout_before", dout, 1'b0);
      if (i == 9) check("bounce_dout_after",  dout, 1'b1);
    end
    check("bounce_count", (gcount == 2), 1'b1);

    // Reset mid-qualification: no glitch, fresh rise after release.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("rstmid_pending_before", pending, 1'b1);
    step(1'b0, 1'b1);
    check("rstmid_dout",    dout,    1'b0);
    check("rstmid_pending", pending, 1'b0);
    check("rstmid_glitch",  glitch,  1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      check("rstmid_no_glitch", glitch, 1'b0);
      if (i == 4) check("rstmid_dout_before", dout, 1'b0);
      if (i == 5) check("rstmid_dout_after",  dout, 1'b1);
    end

    // Randomized runs with lengths around the threshold, rare resets.
    lvl = 1'b0;
    for (int r = 0; r < 600; r++) begin
      len = $urandom_range(1, 7);
      lvl = ~lvl;
      for (int j = 0; j < len; j++) begin
        step(($urandom_range(0, 199) != 0), lvl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_din_debouncer
`default_nettype wire
